// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 + AL422B frame-capture sequencer.
package cam_pkg;

  localparam int unsigned CAM_IMG_W = 320;
  localparam int unsigned CAM_IMG_H = 240;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WRST,
    WRITE,
    RRST,
    READ,
    DONE
  } cam_state_e;

  // {R[4:2], G[5:3], B[4:2]} from an RGB565 word {R5, G6, B5}
  function automatic logic [8:0] rgb565_to_rgb333(input logic [15:0] w);
    return {w[15:13], w[10:8], w[4:2]};
  endfunction

endpackage

// File: rtl/cam_vsync_sync.sv
// Two-flop VSYNC synchronizer with registered rising-edge pulse (3 clk pin-to-pulse).
module cam_vsync_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_in,
  output logic vs_rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      s1      <= vs_in;
      s2      <= s1;
      s3      <= s2;
      vs_rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/cam_fifo_seq.sv
// Capture one camera frame into the AL422B FIFO, then stream it out as RGB333 pixels.
// Optional 2x decimation is enabled by defining CAM_DECIM_EN.
module cam_fifo_seq
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W     = CAM_IMG_W,
  parameter int unsigned IMG_H     = CAM_IMG_H,
  parameter int unsigned WRST_CYC  = 4,
  parameter int unsigned RRST_RCLK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ov_vsync,
  input  logic [7:0] cam_data,
  output logic       fifo_wen,
  output logic       fifo_wrst_n,
  output logic       fifo_rrst_n,
  output logic       fifo_oe_n,
  output logic       fifo_rclk,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [8:0] pix_data,
  output logic [8:0] pix_x,
  output logic [7:0] pix_y,
  output logic       busy,
  output logic       frame_done
);

  cam_state_e state, state_nx;
  logic [7:0] cnt;
  logic       vs_rise;
  logic       ph;        // 0: drive rclk high, 1: drive rclk low and capture
  logic       bsel;      // 0: next byte is high byte, 1: low byte
  logic [7:0] hi_byte;
  logic [8:0] x_cnt;
  logic [7:0] y_cnt;
  logic       all_read;
  logic       step, fire, emit;
  logic [8:0] px;
  logic [7:0] py;

  cam_vsync_sync u_vsync (
    .clk     (clk),
    .rst_n   (rst_n),
    .vs_in   (ov_vsync),
    .vs_rise (vs_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state != state_nx) ? '0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    fifo_wen    = 1'b0;
    fifo_wrst_n = 1'b1;
    fifo_rrst_n = 1'b1;
    fifo_oe_n   = 1'b1;
    frame_done  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = ARM;
      ARM:   if (vs_rise) state_nx = WRST;
      WRST: begin
        fifo_wen    = 1'b1;
        fifo_wrst_n = 1'b0;
        if (cnt == 8'(WRST_CYC - 1)) state_nx = WRITE;
      end
      WRITE: begin
        fifo_wen = ~vs_rise;
        if (vs_rise) state_nx = RRST;
      end
      RRST: begin
        fifo_oe_n   = 1'b0;
        fifo_rrst_n = 1'b0;
        if (cnt == 8'(2 * RRST_RCLK - 1)) state_nx = READ;
      end
      READ: begin
        fifo_oe_n = 1'b0;
        if (all_read && (!pix_valid || pix_ready)) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign fire = pix_valid & pix_ready;
  // Reading pauses entirely while a pixel is waiting for acceptance.
  assign step = (state == READ) && !all_read && !(pix_valid && !pix_ready);

`ifdef CAM_DECIM_EN
  assign emit = ~x_cnt[0] & ~y_cnt[0];
  assign px   = {1'b0, x_cnt[8:1]};
  assign py   = {1'b0, y_cnt[7:1]};
`else
  assign emit = 1'b1;
  assign px   = x_cnt;
  assign py   = y_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rclk <= 1'b0;
      ph        <= 1'b0;
      bsel      <= 1'b0;
      hi_byte   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      all_read  <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      if (state == RRST)
        fifo_rclk <= ~fifo_rclk;
      else if (step)
        fifo_rclk <= ~ph;
      else
        fifo_rclk <= 1'b0;

      if (state != READ) begin
        ph        <= 1'b0;
        bsel      <= 1'b0;
        x_cnt     <= '0;
        y_cnt     <= '0;
        all_read  <= 1'b0;
        pix_valid <= 1'b0;
      end else begin
        if (fire) pix_valid <= 1'b0;
        if (step) begin
          ph <= ~ph;
          if (ph) begin
            bsel <= ~bsel;
            if (!bsel) begin
              hi_byte <= cam_data;
            end else begin
              pix_valid <= emit;
              if (emit) begin
                pix_data <= rgb565_to_rgb333({hi_byte, cam_data});
                pix_x    <= px;
                pix_y    <= py;
              end
              if (x_cnt == 9'(IMG_W - 1)) begin
                x_cnt <= '0;
                if (y_cnt == 8'(IMG_H - 1)) all_read <= 1'b1;
                else                        y_cnt    <= y_cnt + 8'd1;
              end else begin
                x_cnt <= x_cnt + 9'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_fifo_seq.sv
// Self-checking bench for cam_fifo_seq with an AL422B read-port model and pixel reference queue.
module tb_cam_fifo_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned NB = 2 * W * H;
  localparam int unsigned RR = 2;
`ifdef CAM_DECIM_EN
  localparam int STALL_IDX = 1;
`else
  localparam int STALL_IDX = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ov_vsync = 1'b0;
  logic [7:0] cam_data = '0;
  logic       pix_ready = 1'b0;
  logic       fifo_wen, fifo_wrst_n, fifo_rrst_n, fifo_oe_n, fifo_rclk;
  logic       pix_valid, busy, frame_done;
  logic [8:0] pix_data, pix_x;
  logic [7:0] pix_y;

  always #5 clk = ~clk;

  cam_fifo_seq #(
    .IMG_W     (W),
    .IMG_H     (H),
    .WRST_CYC  (4),
    .RRST_RCLK (RR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ov_vsync    (ov_vsync),
    .cam_data    (cam_data),
    .fifo_wen    (fifo_wen),
    .fifo_wrst_n (fifo_wrst_n),
    .fifo_rrst_n (fifo_rrst_n),
    .fifo_oe_n   (fifo_oe_n),
    .fifo_rclk   (fifo_rclk),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // AL422B read side: rclk rising with rrst_n low rewinds, otherwise presents the next byte.
  logic [7:0]  mem [NB];
  int unsigned rptr = 0;
  int unsigned rd_rises = 0;
  int unsigned rr_rises = 0;

  always @(posedge fifo_rclk) begin
    if (!fifo_rrst_n) begin
      rptr = 0;
      rr_rises++;
    end else begin
      cam_data <= mem[rptr % NB];
      rptr++;
      rd_rises++;
    end
  end

  typedef struct {
    logic [8:0] d;
    logic [8:0] x;
    logic [7:0] y;
  } pix_t;
  pix_t expq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string ctx);
    check({ctx, "_wen"},   fifo_wen,    1'b0);
    check({ctx, "_wrst"},  fifo_wrst_n, 1'b1);
    check({ctx, "_rrst"},  fifo_rrst_n, 1'b1);
    check({ctx, "_oe"},    fifo_oe_n,   1'b1);
    check({ctx, "_rclk"},  fifo_rclk,   1'b0);
    check({ctx, "_valid"}, pix_valid,   1'b0);
    check({ctx, "_data"},  pix_data,    9'd0);
    check({ctx, "_x"},     pix_x,       9'd0);
    check({ctx, "_y"},     pix_y,       8'd0);
    check({ctx, "_busy"},  busy,        1'b0);
    check({ctx, "_done"},  frame_done,  1'b0);
  endtask

  // Expected pixel stream computed from the byte image with plain arithmetic.
  task automatic build_expect(input bit fixed);
    int unsigned word, r5, g6, b5;
    pix_t p;
    expq.delete();
    for (int unsigned i = 0; i < NB; i++)
      mem[i] = fixed ? ((i % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom_range(0, 255));
    for (int unsigned i = 0; i < W * H; i++) begin
      word = mem[2 * i] * 256 + mem[2 * i + 1];
      r5 = word / 2048;
      g6 = (word / 32) % 64;
      b5 = word % 32;
      p.d = 9'((r5 / 4) * 64 + (g6 / 8) * 8 + (b5 / 4));
`ifdef CAM_DECIM_EN
      if ((i % W) % 2 == 0 && (i / W) % 2 == 0) begin
        p.x = 9'((i % W) / 2);
        p.y = 8'((i / W) / 2);
        expq.push_back(p);
      end
`else
      p.x = 9'(i % W);
      p.y = 8'(i / W);
      expq.push_back(p);
`endif
    end
  endtask

  task automatic run_frame(input bit fixed, input bit rnd_ready, input int stall_idx,
                           input int abort_after);
    int first_low, low, accepted, done_cnt;
    bit finished, stalled;
    int unsigned snap_rd;
    logic [8:0] sd, sx;
    logic [7:0] sy;
    pix_t p;

    build_expect(fixed);
    rd_rises = 0;
    rr_rises = 0;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("arm_busy", busy, 1'b1);
    check("arm_wen", fifo_wen, 1'b0);
    repeat (3) @(negedge clk);

    ov_vsync = 1'b1;
    first_low = -1;
    low = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!fifo_wrst_n) begin
        if (first_low < 0) first_low = c;
        low++;
        check("wen_in_wrst", fifo_wen, 1'b1);
      end
      if (c == 6) ov_vsync = 1'b0;
    end
    check("wrst_start", first_low, 4);
    check("wrst_len", low, 4);
    check("write_wen", fifo_wen, 1'b1);

    // Start during capture must be dropped.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);

    ov_vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wen_before_rise", fifo_wen, 1'b1);
    @(negedge clk);
    check("wen_fall", fifo_wen, 1'b0);
    @(negedge clk);
    check("rrst_low", fifo_rrst_n, 1'b0);
    check("rrst_oe", fifo_oe_n, 1'b0);
    ov_vsync = 1'b0;

    accepted = 0;
    done_cnt = 0;
    finished = 1'b0;
    stalled  = 1'b0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (done_cnt > 0 && !busy) begin
        finished = 1'b1;
      end else begin
        if (pix_valid && stall_idx == accepted && !stalled) begin
          stalled = 1'b1;
          pix_ready = 1'b0;
          sd = pix_data;
          sx = pix_x;
          sy = pix_y;
          snap_rd = rd_rises;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_valid", pix_valid, 1'b1);
            check("stall_rclk", fifo_rclk, 1'b0);
            check("stall_data", pix_data, sd);
            check("stall_xy", {pix_x, pix_y}, {sx, sy});
          end
          check("stall_no_read", rd_rises, snap_rd);
        end
        pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_valid && pix_ready) begin
          if (expq.size() == 0) begin
            check("extra_pixel", 1, 0);
          end else begin
            p = expq.pop_front();
            check("pix_data", pix_data, p.d);
            check("pix_x", pix_x, p.x);
            check("pix_y", pix_y, p.y);
          end
          accepted++;
          if (accepted == abort_after) begin
            rst_n = 1'b0;
            #1;
            chk_reset("abort");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            check("abort_idle", busy, 1'b0);
            check("abort_nodone", frame_done, 1'b0);
            pix_ready = 1'b0;
            expq.delete();
            return;
          end
        end
      end
    end
    pix_ready = 1'b0;
    check("frame_timeout", finished, 1'b1);
    check("pixels_left", expq.size(), 0);
    check("frame_done_cnt", done_cnt, 1);
    check("bytes_read", rd_rises, NB);
    check("rrst_rclk", rr_rises, RR);
    check("end_oe", fifo_oe_n, 1'b1);
    if (stall_idx >= 0) check("stall_hit", stalled, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    run_frame(1'b1, 1'b0, STALL_IDX, -1);
    run_frame(1'b0, 1'b1, -1, -1);
    run_frame(1'b0, 1'b1, -1, 1);
    run_frame(1'b0, 1'b0, -1, -1);
    run_frame(1'b0, 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
